sprite_blitter: RTL and testbench

- Reads a sprite image out of a synchronous single-port sprite ROM (3-bit colour, 1-cycle read latency) and writes it into the VGA adapter framebuffer at a requested screen origin.
- Owns the ROM address side and the adapter write side.
- Adds transparency keying and screen-edge clipping.
- One draw request draws one full sprite. Draw requests come from the game FSM through a start/busy/done handshake.

---
 rtl/sprite_blitter_if.sv | 37 +++
 rtl/sprite_blitter.sv | 148 ++++++++++++++
 tb/tb_sprite_blitter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/sprite_blitter_if.sv
// sprite_blitter_if: bundles the blitter's draw handshake, sprite ROM port and
// VGA adapter write port.
//   master : the blitter (drives busy/done, rom_addr, vga_*)
//   slave  : the environment (game FSM, ROM, adapter)
// Optional: SPRITE_BLITTER_MIRROR_EN adds the 'mirror' request bit.
interface sprite_blitter_if #(
  parameter int WIDTH_X       = 8,
  parameter int WIDTH_Y       = 7,
  parameter int WIDTH_ADDRESS = 8
);
  logic                     start;
  logic [WIDTH_X-1:0]       org_x;
  logic [WIDTH_Y-1:0]       org_y;
`ifdef SPRITE_BLITTER_MIRROR_EN
  logic                     mirror;
`endif
  logic                     busy;
  logic                     done;
  logic [WIDTH_ADDRESS-1:0] rom_addr;
  logic [2:0]               rom_data;
  logic [WIDTH_X-1:0]       vga_x;
  logic [WIDTH_Y-1:0]       vga_y;
  logic [2:0]               vga_colour;
  logic                     vga_plot;

`ifdef SPRITE_BLITTER_MIRROR_EN
  modport master (input start, org_x, org_y, mirror, rom_data,
                  output busy, done, rom_addr, vga_x, vga_y, vga_colour, vga_plot);
  modport slave  (output start, org_x, org_y, mirror, rom_data,
                  input busy, done, rom_addr, vga_x, vga_y, vga_colour, vga_plot);
`else
  modport master (input start, org_x, org_y, rom_data,
                  output busy, done, rom_addr, vga_x, vga_y, vga_colour, vga_plot);
  modport slave  (output start, org_x, org_y, rom_data,
                  input busy, done, rom_addr, vga_x, vga_y, vga_colour, vga_plot);
`endif
endinterface

// File: rtl/sprite_blitter.sv
// sprite_blitter: copies a SPRITE_W x SPRITE_H sprite from a 1-cycle-latency
// ROM into the VGA framebuffer at (org_x, org_y), skipping TRANSPARENT pixels
// and pixels that fall off the right/bottom screen edge.
// Ports:
//   clk, resetn : clock, asynchronous active-low reset
//   bus         : sprite_blitter_if.master
//                 start/org_x/org_y(/mirror) -> busy/done handshake
//                 rom_addr -> rom_data (colour one cycle later)
//                 vga_x/vga_y/vga_colour/vga_plot adapter write port
// Address-to-plot latency is 2 cycles: ROM cycle (stage 1), output register.
// Optional: define SPRITE_BLITTER_MIRROR_EN for horizontally flipped draws.
module sprite_blitter #(
  parameter int         SPRITE_W      = 16,
  parameter int         SPRITE_H      = 16,
  parameter int         WIDTH_X       = 8,
  parameter int         WIDTH_Y       = 7,
  parameter int         SCREEN_X      = 160,
  parameter int         SCREEN_Y      = 120,
  parameter int         WIDTH_ADDRESS = 8,
  parameter logic [2:0] TRANSPARENT   = 3'b101
) (
  input logic            clk,
  input logic            resetn,
  sprite_blitter_if.master bus
);

  localparam int SXW = $clog2(SPRITE_W);
  localparam int SYW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

  typedef enum logic [1:0] {IDLE, DRAW, FLUSH, DONE} state_t;
  state_t state, state_nxt;

  logic [SXW-1:0]     sx, s1_x, ax;
  logic [SYW-1:0]     sy, s1_y;
  logic [WIDTH_X-1:0] ox;
  logic [WIDTH_Y-1:0] oy;
  logic               mir;
  logic               s1_vld;
  logic               flush_cnt;
  logic               issue;
  logic               accept;
  logic               last_pix;
  logic [WIDTH_X:0]   px;   // one bit wider so off-screen sums never wrap
  logic [WIDTH_Y:0]   py;

  assign accept   = (state == IDLE) && bus.start;
  assign last_pix = (sx == SXW'(SPRITE_W - 1)) && (sy == SYW'(SPRITE_H - 1));

  // ---------------- FSM: state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // ---------------- FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = DRAW;
      DRAW:    if (last_pix)  state_nxt = FLUSH;
      FLUSH:   if (flush_cnt) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs
  always_comb begin
    issue    = (state == DRAW);
    bus.busy = (state == DRAW) || (state == FLUSH);
    bus.done = (state == DONE);
  end

  // ---------------- request latch and sprite scan counters
`ifdef SPRITE_BLITTER_MIRROR_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     mir <= 1'b0;
    else if (accept) mir <= bus.mirror;
  end
`else
  assign mir = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ox        <= '0;
      oy        <= '0;
      sx        <= '0;
      sy        <= '0;
      flush_cnt <= 1'b0;
    end else begin
      if (accept) begin
        ox <= bus.org_x;
        oy <= bus.org_y;
        sx <= '0;
        sy <= '0;
      end else if (issue) begin
        if (sx == SXW'(SPRITE_W - 1)) begin
          sx <= '0;
          sy <= sy + 1'b1;
        end else begin
          sx <= sx + 1'b1;
        end
      end
      flush_cnt <= (state == FLUSH) ? ~flush_cnt : 1'b0;
    end
  end

  // Mirroring only changes which ROM column is fetched; the screen column
  // still comes from sx, so geometry and clipping are identical.
  assign ax = mir ? (SXW'(SPRITE_W - 1) - sx) : sx;
  assign bus.rom_addr = issue ? (WIDTH_ADDRESS'(ax) +
                                 WIDTH_ADDRESS'(sy) * WIDTH_ADDRESS'(SPRITE_W))
                              : '0;

  // ---------------- stage 1: hold coordinate while ROM answers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_vld <= 1'b0;
      s1_x   <= '0;
      s1_y   <= '0;
    end else begin
      s1_vld <= issue;
      s1_x   <= sx;
      s1_y   <= sy;
    end
  end

  // ---------------- output stage: screen coordinate, clip, key
  assign px = {1'b0, ox} + (WIDTH_X + 1)'(s1_x);
  assign py = {1'b0, oy} + (WIDTH_Y + 1)'(s1_y);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.vga_x      <= '0;
      bus.vga_y      <= '0;
      bus.vga_colour <= '0;
      bus.vga_plot   <= 1'b0;
    end else begin
      bus.vga_x      <= px[WIDTH_X-1:0];
      bus.vga_y      <= py[WIDTH_Y-1:0];
      bus.vga_colour <= bus.rom_data;
      bus.vga_plot   <= s1_vld && (bus.rom_data != TRANSPARENT) &&
                        (px < (WIDTH_X + 1)'(SCREEN_X)) &&
                        (py < (WIDTH_Y + 1)'(SCREEN_Y));
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter (4x2 sprite, ROM colour = addr mod 8).
// The driver issues draws and pushes expected addresses, plots and done
// pulses (tagged with their cycle) into queues; an independent monitor on the
// falling edge pops and compares whatever the DUT presents.
module tb_sprite_blitter;
  localparam int W = 4, H = 2, N = W * H;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   cyc = 0;
  int   checks = 0, errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sprite_blitter_if #(.WIDTH_X(8), .WIDTH_Y(7), .WIDTH_ADDRESS(8)) bus ();

  sprite_blitter #(
    .SPRITE_W(W), .SPRITE_H(H), .WIDTH_X(8), .WIDTH_Y(7),
    .SCREEN_X(160), .SCREEN_Y(120), .WIDTH_ADDRESS(8), .TRANSPARENT(3'b101)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  // sprite ROM: one cycle read latency, colour = address mod 8
  always @(posedge clk) bus.rom_data <= bus.rom_addr[2:0];

  typedef struct {int cyc; int x; int y; int c;} plot_t;
  typedef struct {int cyc; int a;} addr_t;
  plot_t pq[$];
  addr_t aq[$];
  int    dq[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, exp);
    end
  endtask

  task automatic flag(input string name, input int at);
    checks++;
    errors++;
    $display("FAIL %s: event at cycle %0d not as required", name, at);
  endtask

  // Reference: a draw accepted at the edge ending cycle t0 issues pixel i
  // (row-major) in cycle t0+1+i, plots it in t0+3+i, done in t0+N+3.
  // Events after cycle lim are not expected (abandoned by reset).
  function automatic void model(int t0, int ox, int oy, int m, int lim);
    for (int i = 0; i < N; i++) begin
      int sx = i % W, sy = i / W;
      int a  = (m != 0) ? (W - 1 - sx) + sy * W : sx + sy * W;
      int c  = a % 8;
      if (t0 + 1 + i <= lim) aq.push_back('{t0 + 1 + i, a});
      if (c != 5 && ox + sx < 160 && oy + sy < 120 && t0 + 3 + i <= lim)
        pq.push_back('{t0 + 3 + i, ox + sx, oy + sy, c});
    end
    if (t0 + N + 3 <= lim) dq.push_back(t0 + N + 3);
  endfunction

  // ---------------- monitor
  always @(negedge clk) begin
    while (pq.size() > 0 && pq[0].cyc < cyc) begin flag("plot_missing", pq[0].cyc); void'(pq.pop_front()); end
    while (aq.size() > 0 && aq[0].cyc < cyc) begin flag("addr_missing", aq[0].cyc); void'(aq.pop_front()); end
    while (dq.size() > 0 && dq[0] < cyc)     begin flag("done_missing", dq[0]);     void'(dq.pop_front()); end
    if (bus.vga_plot) begin
      if (pq.size() > 0) begin
        chk("plot_cycle", cyc, pq[0].cyc);
        chk("vga_x", int'(bus.vga_x), pq[0].x);
        chk("vga_y", int'(bus.vga_y), pq[0].y);
        chk("vga_colour", int'(bus.vga_colour), pq[0].c);
        void'(pq.pop_front());
      end else flag("plot_unexpected", cyc);
    end
    if (aq.size() > 0 && aq[0].cyc == cyc) begin
      chk("rom_addr", int'(bus.rom_addr), aq[0].a);
      void'(aq.pop_front());
    end
    if (bus.done) begin
      if (dq.size() > 0) begin
        chk("done_cycle", cyc, dq[0]);
        void'(dq.pop_front());
      end else flag("done_unexpected", cyc);
    end
  end

  // ---------------- driver
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
  endtask

  // noise: random start pulses and org/mirror changes once the draw is running
  task automatic draw(input int ox, input int oy, input int m, input bit noise);
    int t0;
    @(negedge clk);
    t0 = cyc;
    bus.start = 1'b1;
    bus.org_x = 8'(ox);
    bus.org_y = 7'(oy);
`ifdef SPRITE_BLITTER_MIRROR_EN
    bus.mirror = m[0];
    model(t0, ox, oy, m, 1 << 30);
`else
    model(t0, ox, oy, 0, 1 << 30);
`endif
    for (int k = 1; k <= N + 3; k++) begin
      @(negedge clk);
      bus.start = noise ? 1'($urandom % 2) : 1'b0;
      if (noise) begin
        bus.org_x = (k == 2) ? 8'd50 : 8'($urandom);
        bus.org_y = 7'($urandom);
`ifdef SPRITE_BLITTER_MIRROR_EN
        bus.mirror = 1'($urandom);
`endif
      end
      if (k == 1)     chk("busy_first", int'(bus.busy), 1);
      if (k == N + 2) chk("busy_flush", int'(bus.busy), 1);
      if (k == N + 3) chk("busy_done",  int'(bus.busy), 0);
    end
  endtask

  initial begin
    int t0;
    bus.start = 1'b0;
    bus.org_x = '0;
    bus.org_y = '0;
`ifdef SPRITE_BLITTER_MIRROR_EN
    bus.mirror = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_plot", int'(bus.vga_plot), 0);
    chk("rst_vga_x", int'(bus.vga_x), 0);
    chk("rst_vga_y", int'(bus.vga_y), 0);
    chk("rst_colour", int'(bus.vga_colour), 0);
    chk("rst_rom_addr", int'(bus.rom_addr), 0);
    resetn = 1'b1;
    idle(2);

    draw(10, 20, 0, 1'b0);      // basic draw, colour 5 keyed out
    idle(1);
    draw(158, 119, 0, 1'b0);    // right/bottom clipping
    draw(10, 20, 0, 1'b1);      // spurious starts, org changes mid-draw
    draw(30, 40, 0, 1'b0);      // back-to-back: start in cycle 12
    for (int r = 0; r < 8; r++) begin
      draw(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
           int'($urandom % 2), 1'($urandom));
      idle(int'($urandom_range(0, 2)));
    end
    draw(157, 118, 1, 1'b0);
    draw(0, 0, 1, 1'b0);        // mirrored when the option is built in
    idle(1);

    // reset in cycle 5 of a draw abandons it
    @(negedge clk);
    t0 = cyc;
    bus.start = 1'b1;
    bus.org_x = 8'd20;
    bus.org_y = 7'd30;
`ifdef SPRITE_BLITTER_MIRROR_EN
    bus.mirror = 1'b0;
`endif
    model(t0, 20, 30, 0, t0 + 5);
    idle(5);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_plot", int'(bus.vga_plot), 0);
    chk("mid_rst_done", int'(bus.done), 0);
    idle(2);
    resetn = 1'b1;
    idle(N + 6);

    draw(5, 5, 0, 1'b0);        // recovers after abandoned draw
    idle(6);
    chk("plot_queue_empty", pq.size(), 0);
    chk("addr_queue_empty", aq.size(), 0);
    chk("done_queue_empty", dq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1);
  end
endmodule
